jk_bank_driver: RTL and testbench

Sequential driver for an N-bit bank of JK flip-flops: the control side of the JK interface. It accepts target words over a valid/ready handshake and converts each word to per-bit J/K excitation using the standard JK excitation table. It tracks the expected bank state internally, then checks the bank's Q feedback one cycle after the bank samples. It sits between a sequence source (bench or controller FSM) and the JK register bank.

---
 rtl/jk_bank_driver.sv | 113 +++++++++++
 tb/tb_jk_bank_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// Control side of a JK flip-flop bank: turns target words into J/K
// excitation, tracks the expected bank state and checks Q feedback.
module jk_bank_driver #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] INIT_Q      = '0,
    parameter int               TOGGLE_MODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             mismatch,
    output logic [WIDTH-1:0] err_bits,
    input  logic             clear_err
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] exp_nxt;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] tgt_nxt;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic             mismatch_nxt;
    logic [WIDTH-1:0] err_bits_nxt;
    logic [WIDTH-1:0] diff;

    assign tgt_ready = (state == IDLE) & ~reset;
    assign busy      = (state != IDLE);
    assign diff      = tgt_data ^ exp;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            exp      <= INIT_Q;
            tgt      <= '0;
            j        <= '0;
            k        <= '0;
            mismatch <= 1'b0;
            err_bits <= '0;
        end else begin
            state    <= state_nxt;
            exp      <= exp_nxt;
            tgt      <= tgt_nxt;
            j        <= j_nxt;
            k        <= k_nxt;
            mismatch <= mismatch_nxt;
            err_bits <= err_bits_nxt;
        end
    end

    // j/k default to hold so the bank only ever sees drive during APPLY
    always_comb begin
        state_nxt    = state;
        exp_nxt      = exp;
        tgt_nxt      = tgt;
        j_nxt        = '0;
        k_nxt        = '0;
        mismatch_nxt = mismatch;
        err_bits_nxt = err_bits;
        unique case (state)
            IDLE: begin
                if (tgt_valid && tgt_ready) begin
                    tgt_nxt   = tgt_data;
                    state_nxt = APPLY;
                    if (TOGGLE_MODE != 0) begin
                        j_nxt = diff;
                        k_nxt = diff;
                    end else begin
                        j_nxt = tgt_data & ~exp;
                        k_nxt = ~tgt_data & exp;
                    end
                end
            end
            APPLY: begin
                exp_nxt   = tgt;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (q_fb != exp) begin
                    mismatch_nxt = 1'b1;
                    err_bits_nxt = err_bits | (q_fb ^ exp);
                    state_nxt    = ERROR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ERROR: begin
                // resync to whatever the bank actually holds
                if (clear_err) begin
                    exp_nxt      = q_fb;
                    mismatch_nxt = 1'b0;
                    err_bits_nxt = '0;
                    state_nxt    = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver: two instances (set/reset and toggle
// excitation) each driving a behavioural JK bank with optional stuck bits.
module tb_jk_bank_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic       tgt_valid;
    logic [3:0] tgt_data;
    logic       clear_err;
    logic [3:0] stuck;

    logic       rdy0, rdy1;
    logic       busy0, busy1;
    logic       mis0, mis1;
    logic [3:0] j0, k0, j1, k1;
    logic [3:0] eb0, eb1;
    logic [3:0] bank0, bank1;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    jk_bank_driver #(.WIDTH(4), .INIT_Q(4'b0000), .TOGGLE_MODE(0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (rdy0),
        .q_fb      (bank0),
        .j         (j0),
        .k         (k0),
        .busy      (busy0),
        .mismatch  (mis0),
        .err_bits  (eb0),
        .clear_err (clear_err)
    );

    jk_bank_driver #(.WIDTH(4), .INIT_Q(4'b0000), .TOGGLE_MODE(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (rdy1),
        .q_fb      (bank1),
        .j         (j1),
        .k         (k1),
        .busy      (busy1),
        .mismatch  (mis1),
        .err_bits  (eb1),
        .clear_err (clear_err)
    );

    function automatic logic [3:0] jk_next(logic [3:0] q, logic [3:0] jj,
                                           logic [3:0] kk);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) begin
            unique case ({jj[b], kk[b]})
                2'b00: n[b] = q[b];
                2'b01: n[b] = 1'b0;
                2'b10: n[b] = 1'b1;
                2'b11: n[b] = ~q[b];
            endcase
        end
        return n;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            bank0 <= '0;
            bank1 <= '0;
        end else begin
            bank0 <= jk_next(bank0, j0, k0) & ~stuck;
            bank1 <= jk_next(bank1, j1, k1) & ~stuck;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // full handshake/APPLY/CHECK sequence with a good bank
    task automatic send(logic [3:0] d, logic [3:0] ej0, logic [3:0] ek0,
                        logic [3:0] ejt);
        chk("pre_ready", {31'b0, rdy0 & rdy1}, 1);
        tgt_valid = 1'b1;
        tgt_data  = d;
        tick();
        tgt_valid = 1'b0;
        chk("apply_j0", j0, ej0);
        chk("apply_k0", k0, ek0);
        chk("apply_j1", j1, ejt);
        chk("apply_k1", k1, ejt);
        chk("apply_busy", {30'b0, busy0, busy1}, 3);
        chk("apply_rdy", {30'b0, rdy0, rdy1}, 0);
        tick();
        chk("check_jk", {j0, k0, j1, k1}, 0);
        chk("bank0", bank0, d);
        chk("bank1", bank1, d);
        tick();
        chk("done_rdy", {30'b0, rdy0, rdy1}, 3);
        chk("done_mis", {30'b0, mis0, mis1}, 0);
        chk("done_eb", {eb0, eb1}, 0);
    endtask

    initial begin
        reset     = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        clear_err = 1'b0;
        stuck     = '0;
        tick();
        tick();
        chk("rst_jk", {j0, k0, j1, k1}, 0);
        chk("rst_busy", {30'b0, busy0, busy1}, 0);
        chk("rst_rdy", {30'b0, rdy0, rdy1}, 0);
        chk("rst_err", {22'b0, mis0, mis1, eb0, eb1}, 0);
        reset = 1'b0;
        tick();
        chk("idle_rdy", {30'b0, rdy0, rdy1}, 3);

        send(4'b1010, 4'b1010, 4'b0000, 4'b1010);
        send(4'b0110, 4'b0100, 4'b1000, 4'b1100);
        send(4'b0101, 4'b0001, 4'b0010, 4'b0011);
        send(4'b0000, 4'b0000, 4'b0101, 4'b0101);

        // bit0 stuck at 0
        stuck     = 4'b0001;
        tgt_valid = 1'b1;
        tgt_data  = 4'b0001;
        tick();
        tgt_valid = 1'b0;
        chk("stk_j", {j0, j1}, 8'h11);
        tick();
        tick();
        chk("stk_mis", {30'b0, mis0, mis1}, 3);
        chk("stk_eb", {eb0, eb1}, 8'h11);
        chk("stk_rdy", {30'b0, rdy0, rdy1}, 0);
        tick();
        chk("err_hold", {30'b0, rdy0, rdy1}, 0);
        chk("err_jk", {j0, k0, j1, k1}, 0);
        chk("err_sticky", {30'b0, mis0, mis1}, 3);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("clr_mis", {22'b0, mis0, mis1, eb0, eb1}, 0);
        chk("clr_rdy", {30'b0, rdy0, rdy1}, 3);
        stuck = '0;
        send(4'b0001, 4'b0001, 4'b0000, 4'b0001);

        // reset during APPLY
        tgt_valid = 1'b1;
        tgt_data  = 4'b0011;
        tick();
        tgt_valid = 1'b0;
        chk("rap_j0", j0, 4'b0010);
        chk("rap_j1", j1, 4'b0010);
        reset = 1'b1;
        tick();
        chk("rap_jk", {j0, k0, j1, k1}, 0);
        chk("rap_busy", {30'b0, busy0, busy1}, 0);
        chk("rap_rdy", {30'b0, rdy0, rdy1}, 0);
        reset = 1'b0;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("idle_clr", {28'b0, rdy0, rdy1, busy0, busy1}, 4'b1100);
        send(4'b0001, 4'b0001, 4'b0000, 4'b0001);

        // held valid with a repeated word
        tgt_valid = 1'b1;
        tgt_data  = 4'b0011;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (n == 0) begin
                chk("rep_j0", {j0, k0}, 8'h20);
                chk("rep_j1", {j1, k1}, 8'h22);
            end else begin
                chk("rep_jk", {j0, k0, j1, k1}, 0);
            end
            chk("rep_busy", {30'b0, busy0, busy1}, 3);
            tick();
            chk("rep_chk", {j0, k0, j1, k1}, 0);
            tick();
            chk("rep_rdy", {30'b0, rdy0, rdy1}, 3);
            chk("rep_mis", {30'b0, mis0, mis1}, 0);
            chk("rep_bank", {bank0, bank1}, 8'h33);
        end
        tgt_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
